key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter NKEYS, default 7: number of button inputs; legal range 1..8.
REQ-002 Parameter TICK_DIV, default 24000: clk cycles per sample tick (1 ms at 24 MHz); minimum 16.
REQ-003 Parameter STABLE_TICKS, default 10: consecutive disagreeing samples needed to accept a level change; legal range 1..15.
REQ-004 Parameter FIFO_DEPTH, default 8: event FIFO entries; power of two, minimum 2.
REQ-005 clk  input  1  system clock, 24 MHz, single clock domain.
REQ-006 resetn  input  1  reset, asynchronous assert, active-low.
REQ-007 key_raw  input  NKEYS  raw button pins, asynchronous, active-low (0 = pressed).
REQ-008 key_state  output  NKEYS  debounced level in pin polarity, drop-in replacement for the gp_in button bits.
REQ-009 evt_valid  output  1  event FIFO non-empty.
REQ-010 evt_data  output  4  head event: bit3 = 1 for press, 0 for release; bits2:0 = key index.
REQ-011 evt_ready  input  1  consumer pop request.
REQ-012 evt_ovf  output  1  sticky overflow flag.
REQ-013 ovf_clr  input  1  single-cycle clear of evt_ovf.

Function
REQ-014 Each key_raw bit shall pass through a 2-flop synchronizer whose flops reset to 1; only the second-stage output is used.
REQ-015 A free-running prescaler shall count 0..TICK_DIV-1 and assert a one-cycle tick on the cycle it wraps to 0.
REQ-016 Per key, on tick: if the synchronized sample equals key_state, the 4-bit stability counter clears to 0; otherwise it increments.
REQ-017 When the increment would reach STABLE_TICKS, key_state for that key shall toggle on that same tick edge, the counter shall clear, and the key's pending-event bit shall set.
REQ-018 A glitch shorter than STABLE_TICKS consecutive ticks shall never change key_state or generate an event.
REQ-019 Pending bits drain one per cycle, lowest key index first, starting the cycle after the tick; each drain writes {~key_state[i], i} into the FIFO.
REQ-020 All pending bits shall have drained before the next tick, which TICK_DIV >= 16 guarantees.
REQ-021 The FIFO write is dropped if the FIFO is full and no pop occurs in the same cycle; the drop sets evt_ovf, and the pending bit still clears.
REQ-022 On a simultaneous pop and write while full, both shall take effect, with no drop and no overflow.
REQ-023 evt_valid shall assert the cycle after the first write into an empty FIFO; there is no same-cycle bypass.
REQ-024 Pop occurs on any clk edge with evt_valid && evt_ready; evt_data shows the next entry in the following cycle, or is held if the FIFO is now empty.
REQ-025 evt_ready while evt_valid is 0 shall have no effect.
REQ-026 evt_data and evt_valid shall depend only on registered state; the outputs are combinational-free.
REQ-027 FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full is defined as the MSBs differing with the remaining bits equal.
REQ-028 If ovf_clr and a drop occur in the same cycle, the set wins and evt_ovf = 1.

Reset
REQ-029 While resetn = 0: synchronizer flops = 1, key_state = all 1, stability counters = 0, pending = 0, prescaler = 0, FIFO empty (evt_valid = 0, evt_data = 0), evt_ovf = 0.
REQ-030 Reset asserted mid-operation shall discard all queued and pending events, with no partial drain after release.
REQ-031 The first tick after resetn rises shall occur TICK_DIV cycles later.

Verification
REQ-032 (TICK_DIV=16, STABLE_TICKS=3) Hold key_raw[2] = 0 from reset -> key_state[2] falls at the 3rd tick, and evt_data = 4'b1010 with evt_valid = 1 two cycles later.
REQ-033 key_raw[0] low for 2 ticks then high -> key_state unchanged, no event, evt_valid stays 0.
REQ-034 Keys 1, 4 and 6 stable-low on the same tick -> three FIFO entries in order 4'b1001, 4'b1100, 4'b1110, popped back-to-back with evt_ready held at 1.
REQ-035 FIFO_DEPTH=2, evt_ready=0, three press events -> the first two are retained, evt_ovf = 1; ovf_clr -> evt_ovf = 0; then pop and release events -> correct order with no stale entry.
REQ-036 resetn pulsed low while two events are queued and one is pending -> evt_valid = 0 immediately, key_state = 7'h7F, no event appears after release until a new stable change.
REQ-037 Full FIFO with simultaneous pop and new event -> occupancy unchanged, evt_ovf stays 0, the new event is last in order.

Source files
------------

// File: rtl/key_debounce.sv
// Debounces active-low push buttons on a slow sample tick and queues
// press/release events in a small FIFO with a sticky overflow flag.
module key_debounce #(
  parameter int NKEYS        = 7,
  parameter int TICK_DIV     = 24000,
  parameter int STABLE_TICKS = 10,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [NKEYS-1:0] key_raw,
  output logic [NKEYS-1:0] key_state,
  output logic             evt_valid,
  output logic [3:0]       evt_data,
  input  logic             evt_ready,
  output logic             evt_ovf,
  input  logic             ovf_clr
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [NKEYS-1:0] sync1_q, sync2_q;
  logic [PW-1:0]    presc_q, presc_d;
  logic [NKEYS-1:0] key_q, key_d;
  logic [3:0]       cnt_q [NKEYS];
  logic [3:0]       cnt_d [NKEYS];
  logic [NKEYS-1:0] pend_q, pend_d;
  logic [3:0]       mem_q [FIFO_DEPTH];
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic             valid_q, valid_d;
  logic [3:0]       data_q, data_d;
  logic             ovf_q, ovf_d;

  logic             tick_s;
  logic [NKEYS-1:0] drain_oh_s;
  logic [3:0]       wr_data_s;
  logic             wr_s, full_s, pop_s, push_s, drop_s, found_s;

  assign key_state = key_q;
  assign evt_valid = valid_q;
  assign evt_data  = data_q;
  assign evt_ovf   = ovf_q;

  // Prescaler wrap defines the sample tick
  always_comb begin
    tick_s  = (presc_q == PW'(TICK_DIV - 1));
    presc_d = tick_s ? '0 : presc_q + PW'(1);
  end

  // Lowest-index pending key drains first; event encodes the new level
  always_comb begin
    drain_oh_s = '0;
    wr_data_s  = 4'd0;
    found_s    = 1'b0;
    for (int i = 0; i < NKEYS; i++) begin
      if (pend_q[i] && !found_s) begin
        found_s       = 1'b1;
        drain_oh_s[i] = 1'b1;
        wr_data_s     = {~key_q[i], 3'(i)};
      end else begin
        found_s = found_s;
      end
    end
    wr_s = found_s;
  end

  // Per-key stability counters and level toggling on each tick
  always_comb begin
    key_d  = key_q;
    pend_d = pend_q & ~drain_oh_s;
    for (int i = 0; i < NKEYS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!tick_s) begin
        cnt_d[i] = cnt_q[i];
      end else if (sync2_q[i] == key_q[i]) begin
        cnt_d[i] = 4'd0;
      end else if (cnt_q[i] + 4'd1 == 4'(STABLE_TICKS)) begin
        key_d[i]  = ~key_q[i];
        cnt_d[i]  = 4'd0;
        pend_d[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + 4'd1;
      end
    end
  end

  // FIFO control: a pop frees the slot so a write while full still lands
  always_comb begin
    full_s = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    pop_s  = valid_q && evt_ready;
    push_s = wr_s && (!full_s || pop_s);
    drop_s = wr_s && full_s && !pop_s;
    wptr_d = push_s ? wptr_q + PTR_ONE : wptr_q;
    rptr_d = pop_s  ? rptr_q + PTR_ONE : rptr_q;
    valid_d = (wptr_d != rptr_d);
    if (!valid_d) begin
      data_d = data_q;
    end else if (rptr_d == wptr_q) begin
      data_d = wr_data_s;
    end else begin
      data_d = mem_q[rptr_d[AW-1:0]];
    end
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Event storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wptr_q[AW-1:0]] <= wr_data_s;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= '1;
      sync2_q <= '1;
      presc_q <= '0;
      key_q   <= '1;
      cnt_q   <= '{default: 4'd0};
      pend_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= 4'd0;
      ovf_q   <= 1'b0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      presc_q <= presc_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed test of key_debounce with a fast tick (16 clocks, 3 stable samples);
// instance a has an 8-deep FIFO, instance b a 2-deep FIFO.
module tb_key_debounce;

  logic       clk = 1'b0;
  logic       resetn;
  logic [6:0] a_raw, b_raw, a_state, b_state;
  logic       a_valid, b_valid, a_ready, b_ready, a_ovf, b_ovf, a_clr, b_clr;
  logic [3:0] a_data, b_data;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;

  always #5 clk = ~clk;

  key_debounce #(.NKEYS(7), .TICK_DIV(16), .STABLE_TICKS(3), .FIFO_DEPTH(8)) u_a (
    .clk(clk), .resetn(resetn), .key_raw(a_raw), .key_state(a_state),
    .evt_valid(a_valid), .evt_data(a_data), .evt_ready(a_ready),
    .evt_ovf(a_ovf), .ovf_clr(a_clr));

  key_debounce #(.NKEYS(7), .TICK_DIV(16), .STABLE_TICKS(3), .FIFO_DEPTH(2)) u_b (
    .clk(clk), .resetn(resetn), .key_raw(b_raw), .key_state(b_state),
    .evt_valid(b_valid), .evt_data(b_data), .evt_ready(b_ready),
    .evt_ovf(b_ovf), .ovf_clr(b_clr));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  initial begin
    resetn  = 1'b0;
    a_raw   = 7'h7B;
    b_raw   = 7'h7F;
    a_ready = 1'b0;
    b_ready = 1'b0;
    a_clr   = 1'b0;
    b_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_state", {1'b0, a_state}, 8'h7F);
    check("rst_a_valid", {7'd0, a_valid}, 8'h00);
    check("rst_a_data",  {4'd0, a_data},  8'h00);
    check("rst_a_ovf",   {7'd0, a_ovf},   8'h00);
    check("rst_b_state", {1'b0, b_state}, 8'h7F);
    resetn = 1'b1;
    cyc    = 0;

    // key 2 held low from reset: falls on the third tick (edge 48)
    run_to(47);
    check("k2_pre_tick3", {1'b0, a_state}, 8'h7F);
    run_to(48);
    check("k2_fall",       {1'b0, a_state}, 8'h7B);
    check("k2_no_bypass",  {7'd0, a_valid}, 8'h00);
    run_to(49);
    check("k2_evt_valid",  {7'd0, a_valid}, 8'h01);
    check("k2_evt_data",   {4'd0, a_data},  8'h0A);
    a_ready  = 1'b1;
    a_raw[0] = 1'b0;
    run_to(50);
    check("k2_pop_empty",  {7'd0, a_valid}, 8'h00);
    check("k2_data_held",  {4'd0, a_data},  8'h0A);
    a_ready = 1'b0;

    // key 0 glitch: low across two ticks only
    run_to(81);
    a_raw[0] = 1'b1;
    run_to(97);
    check("glitch_state_a", {1'b0, a_state}, 8'h7B);
    check("glitch_valid_a", {7'd0, a_valid}, 8'h00);
    run_to(130);
    check("glitch_state_b", {1'b0, a_state}, 8'h7B);
    check("glitch_valid_b", {7'd0, a_valid}, 8'h00);

    // keys 1, 4, 6 press on the same tick (edge 176)
    a_raw = 7'h29;
    run_to(176);
    check("multi_state",  {1'b0, a_state}, 8'h29);
    run_to(179);
    check("multi_valid",  {7'd0, a_valid}, 8'h01);
    check("multi_head1",  {4'd0, a_data},  8'h09);
    a_ready = 1'b1;
    run_to(180);
    check("multi_head2",  {4'd0, a_data},  8'h0C);
    run_to(181);
    check("multi_head3",  {4'd0, a_data},  8'h0E);
    check("multi_valid3", {7'd0, a_valid}, 8'h01);
    run_to(182);
    check("multi_empty",  {7'd0, a_valid}, 8'h00);
    a_ready = 1'b0;

    // depth-2 FIFO: keys 0, 1, 2 press at edge 224, third event dropped
    b_raw = 7'h78;
    run_to(224);
    check("ovf_state",   {1'b0, b_state}, 8'h78);
    run_to(226);
    check("ovf_full",    {7'd0, b_valid}, 8'h01);
    check("ovf_not_yet", {7'd0, b_ovf},   8'h00);
    b_clr = 1'b1;
    run_to(227);
    check("ovf_set_wins", {7'd0, b_ovf},  8'h01);
    check("ovf_head",     {4'd0, b_data}, 8'h08);
    run_to(228);
    check("ovf_cleared",  {7'd0, b_ovf},  8'h00);
    b_clr    = 1'b0;
    b_raw[0] = 1'b1;

    // key 0 release lands on a full FIFO in the same cycle as a pop
    run_to(272);
    check("full_state",  {1'b0, b_state}, 8'h79);
    check("full_head",   {4'd0, b_data},  8'h08);
    b_ready = 1'b1;
    run_to(273);
    check("popw_head",   {4'd0, b_data},  8'h09);
    check("popw_valid",  {7'd0, b_valid}, 8'h01);
    check("popw_ovf",    {7'd0, b_ovf},   8'h00);
    run_to(274);
    check("popw_last",   {4'd0, b_data},  8'h00);
    check("popw_valid2", {7'd0, b_valid}, 8'h01);
    run_to(275);
    check("popw_empty",  {7'd0, b_valid}, 8'h00);
    b_ready = 1'b0;

    // keys 3, 4, 5 press at edge 320; reset with two queued, one pending
    run_to(276);
    b_raw = 7'h41;
    run_to(322);
    check("mid_state",  {1'b0, b_state}, 8'h41);
    check("mid_valid",  {7'd0, b_valid}, 8'h01);
    check("mid_head",   {4'd0, b_data},  8'h0B);
    resetn = 1'b0;
    #1;
    check("mid_rst_valid", {7'd0, b_valid}, 8'h00);
    check("mid_rst_state", {1'b0, b_state}, 8'h7F);
    check("mid_rst_data",  {4'd0, b_data},  8'h00);
    b_raw = 7'h7F;
    step();
    step();
    resetn = 1'b1;
    for (int k = 0; k < 60; k++) begin
      step();
      check("post_rst_valid", {7'd0, b_valid}, 8'h00);
    end
    check("post_rst_state", {1'b0, b_state}, 8'h7F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
